// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, the default operand width and a helper
// that sizes the bit counter for a given operand width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must index bits 0..width-1; keep at least one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin (mod 2), bout = borrow out.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: a, b, bin (inputs); d (difference bit), bout (borrow out).
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: difference = minuend - subtrahend - borrow_in.
// Latency: accept in cycle 0, WIDTH shift cycles, out_valid from cycle WIDTH+1.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + minuend, subtrahend,
//   borrow_in; out_valid/out_ready + difference, borrow_out; busy.
// Optional: SERIAL_SUBTRACTOR_OVERFLOW_EN adds the signed overflow output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             busy
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             bout_q;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             ovf_q;
`endif

  // The only arithmetic in the block: one cell fed from the shift-register LSBs.
  full_subtractor_bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt_q == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = SHIFT;
      SHIFT:   if (last_bit)  state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand shift registers, borrow flop, difference register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= minuend;
            b_q   <= subtrahend;
            br_q  <= borrow_in;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= cell_bout;
          // LSB-first result enters at the MSB end; after WIDTH shifts it is aligned.
          diff_q <= {cell_d, diff_q[WIDTH-1:1]};
          if (last_bit) begin
            bout_q <= cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            ovf_q  <= br_q ^ cell_bout;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs are decodes of flops only; no input reaches an output combinationally.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign difference = diff_q;
  assign borrow_out = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): randomized and directed operations,
// results checked by a scoreboard fed from an arithmetic reference model.
// Also checks the one-bit cell exhaustively and the handshake timing.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] difference;
  logic         borrow_out;
  logic         busy;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         overflow;
`endif

  logic ca, cb, cbin, cd, cbo;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_acc = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .difference (difference),
    .borrow_out (borrow_out),
    .busy       (busy)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  full_subtractor_bit u_cell_tb (
    .a    (ca),
    .b    (cb),
    .bin  (cbin),
    .d    (cd),
    .bout (cbo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int a, input int b, input int bin);
    exp_t m;
    int r, sa, sb, sr;
    r   = a - b - bin;
    m.d = W'(r);
    m.b = (r < 0);
    sa  = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb  = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sr  = sa - sb - bin;
    m.o = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    return m;
  endfunction

  // Scoreboard monitor: a result is consumed where out_valid && out_ready
  // hold during the cycle (sampled mid-cycle, away from the edge).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got diff 0x%0h with empty scoreboard", difference);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_difference", 32'(difference), 32'(e.d));
        check("sb_borrow_out", 32'(borrow_out), 32'(e.b));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        check("sb_overflow", 32'(overflow), 32'(e.o));
`endif
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                      input bit push, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    minuend    = a;
    subtrahend = b;
    borrow_in  = bin;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    last_acc   = cyc;
    if (push) sb_q.push_back(e);
  endtask

  task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    send(a, b, bin, 1'b1, model(int'(a), int'(b), int'(bin)));
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int   cycles;
    int   prev;
    logic saw_valid;
    logic [W-1:0] a, b, s;
    exp_t e;
    logic [2:0] v;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    minuend = '0; subtrahend = '0; borrow_in = 1'b0;
    ca = 1'b0; cb = 1'b0; cbin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_difference", 32'(difference), 32'd0);
    check("rst_borrow_out", 32'(borrow_out), 32'd0);

    // Exhaustive one-bit cell.
    for (int i = 0; i < 8; i++) begin
      int r;
      v = 3'(i);
      {ca, cb, cbin} = v;
      #1;
      r = int'(ca) - int'(cb) - int'(cbin);
      check("cell_d", 32'(cd), 32'(r & 1));
      check("cell_bout", 32'(cbo), 32'(r < 0));
    end

    // Basic operation and latency: out_valid 9 cycles after the accept edge's cycle 0.
    send_m(8'h5A, 8'h21, 1'b0);
    check("busy_in_shift", 32'(busy), 32'd1);
    wait_valid(cycles);
    check("latency_cycles", 32'(cycles + 1), 32'(W + 1));
    wait_idle();

    // Underflow.
    send_m(8'h00, 8'h01, 1'b1);
    wait_idle();
    send_m(8'h00, 8'h80, 1'b0);
    wait_idle();
    send_m(8'h7F, 8'hFF, 1'b0);
    wait_idle();

    // Backpressure: hold result 5 cycles with in_valid pulsed, then release.
    out_ready = 1'b0;
    e = model(8'hC3, 8'h3C, 1);
    send_m(8'hC3, 8'h3C, 1'b1);
    wait_valid(cycles);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; minuend = 8'h11; subtrahend = 8'h22; borrow_in = 1'b0;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_difference", 32'(difference), 32'(e.d));
      check("bp_borrow_out", 32'(borrow_out), 32'(e.b));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(in_ready), 32'd1);

    // Reset during SHIFT cycle 3 aborts the operation.
    send(8'h96, 8'h35, 1'b0, 1'b0, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_difference", 32'(difference), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      saw_valid |= out_valid;
      @(posedge clk); #1;
    end
    check("abort_no_out_valid", 32'(saw_valid), 32'd0);
    send_m(8'hFF, 8'h0F, 1'b0);
    wait_valid(cycles);
    check("after_abort_diff", 32'(difference), 32'h0F0);
    wait_idle();

    // Adder round trip, back-to-back with out_ready tied high.
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      s = a + b;
      e   = model(int'(s), int'(b), 0);
      e.d = a;
      send(s, b, 1'b0, 1'b1, e);
      if (i > 0) check("throughput_interval", 32'(last_acc - prev), 32'(W + 2));
      prev = last_acc;
    end

    // Drain and confirm every expected result was seen.
    cycles = 0;
    while (sb_q.size() != 0 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial, LSB-first subtractor: the inverse of the combinational full adder.
- Accepts a WIDTH-bit minuend, subtrahend and borrow-in over a valid/ready handshake, then resolves one bit per clock through a single one-bit full-subtractor cell and a borrow flop.
- Returns the difference and final borrow over a second valid/ready handshake.
- Use: recovering an adder operand on chip (a = sum − b) for adder self-check paths, at one-bit-cell area cost.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- minuend  input  WIDTH  operand A.
- subtrahend  input  WIDTH  operand B.
- borrow_in  input  1  initial borrow.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- difference  output  WIDTH  A − B − borrow_in mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when A < B + borrow_in (unsigned).
- busy  output  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A, B and borrow_in into shift registers; clear the bit counter; go to SHIFT.
- SHIFT:
  - Each cycle, the cell computes d = a0 ^ b0 ^ br and br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the difference register MSB-end. A and B shift right. The borrow flop takes br'.
  - When the counter reaches WIDTH−1: go to DONE.
- DONE:
  - out_valid=1. difference, borrow_out and (if enabled) overflow are stable.
  - On out_ready: go to IDLE.
- in_ready=0 outside IDLE. in_valid is ignored in SHIFT and DONE; there is no queuing.
- Counter width: $clog2(WIDTH). It does not wrap in normal use because it is cleared on accept.
- Simultaneous out_ready in DONE and in_valid: in_ready is still 0 in that cycle, so the new operands are accepted one cycle later, in IDLE. No bypass.
- out_valid must not drop until out_ready is seen. Output values hold while out_valid=1.

## Timing
- Reset values:
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - difference=0, borrow_out=0, overflow=0.
  - Counter and shift registers=0.
- Reset mid-operation (SHIFT or DONE) aborts the operation: no out_valid, the partial result is discarded, and the block is in IDLE the next cycle.
- Latency:
  - Accept edge at cycle 0.
  - SHIFT occupies cycles 1..WIDTH.
  - out_valid first high in cycle WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when out_ready is tied high.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit, reset 0).
  - overflow is valid with out_valid: signed two's-complement overflow of A − B − borrow_in.
  - Computed as the borrow into the MSB XOR borrow out of the MSB, captured during the final SHIFT cycle.
- Undefined: the port and its logic are absent; everything else is identical.

## Structure
- Package serial_subtractor_pkg holds:
  - the state enum (IDLE, SHIFT, DONE, 2 bits);
  - the DEFAULT_WIDTH constant (8);
  - a function computing the counter width.
- Sub-module full_subtractor_bit: purely combinational one-bit cell.
  - Inputs a, b, bin; outputs d, bout.
  - Instantiated once, and unit-testable exhaustively (8 vectors).

## Test plan
- Reset and exhaustive cell check:
  - After rst, check in_ready=1, out_valid=0, difference=0.
  - Drive full_subtractor_bit through all 8 input combinations -> correct truth table.
- Basic operation, WIDTH=8:
  - A=0x5A, B=0x21, bin=0, out_ready=1.
  - -> out_valid in cycle 9; difference=0x39, borrow_out=0.
- Underflow, WIDTH=8:
  - A=0x00, B=0x01, bin=1.
  - -> difference=0xFE, borrow_out=1.
  - With the macro defined: 0x00, 0x80, bin=0 -> difference=0x80, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable and out_valid=1 throughout.
  - in_valid pulsed meanwhile -> ignored.
  - Result released on the cycle out_ready rises.
- Reset mid-operation:
  - Assert rst during SHIFT cycle 3 -> IDLE next cycle, out_valid never asserted.
  - Next operation (0xFF − 0x0F) -> 0xF0.
- Back-to-back with adder round-trip:
  - 256 random (a, b) pairs: feed a+b mod 256 as A and b as B, bin=0.
  - -> difference==a every time, one result per 10 cycles.
